// File: rtl/anc_pkg.sv
// Shared types and helpers for the adaptive noise-cancelling LMS engine:
// FSM state encoding, default widths and a generic two's-complement clamp.
package anc_pkg;

  localparam int DEF_TAPS       = 64;
  localparam int DEF_SAMPLE_W   = 16;
  localparam int DEF_COEFF_W    = 16;
  localparam int DEF_COEFF_FRAC = 14;
  localparam int DEF_LEAK_SHIFT = 12;

  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT,
    ST_UPDATE,
    ST_CLEAR
  } state_t;

  // Clamp a wide signed value to the range of an n-bit two's-complement word.
  function automatic wide_t sat_to(input wide_t v, input int n);
    wide_t max_v;
    wide_t min_v;
    max_v = (wide_t'(1) <<< (n - 1)) - wide_t'(1);
    min_v = -max_v - wide_t'(1);
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction

endpackage

// File: rtl/anc_lms_engine_if.sv
// Sample stream between the front end and the LMS engine: sample pair in,
// anti-noise sample out, plus the dropped-sample strobe.
interface anc_lms_engine_if #(
  parameter int SAMPLE_W = 16
) ();

  logic                       ready_in;
  logic signed [SAMPLE_W-1:0] x_in;
  logic signed [SAMPLE_W-1:0] e_in;
  logic signed [SAMPLE_W-1:0] y_out;
  logic                       y_valid_out;
  logic                       drop_out;

  modport master (
    output ready_in, x_in, e_in,
    input  y_out, y_valid_out, drop_out
  );

  modport slave (
    input  ready_in, x_in, e_in,
    output y_out, y_valid_out, drop_out
  );

endinterface

// File: rtl/lms_delay_line.sv
// TAPS-deep ring buffer of reference samples; read port addresses the k-th
// most recent sample, wrapping around the buffer.
module lms_delay_line #(
  parameter int TAPS     = 64,
  parameter int SAMPLE_W = 16,
  parameter int PTR_W    = $clog2(TAPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic signed [SAMPLE_W-1:0] wr_data,
  input  logic        [PTR_W-1:0]    rd_k,
  output logic signed [SAMPLE_W-1:0] rd_data
);

  logic signed [SAMPLE_W-1:0] buf_q [TAPS];
  logic        [PTR_W-1:0]    wr_ptr;
  logic        [PTR_W-1:0]    rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < TAPS; i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      buf_q[wr_ptr] <= wr_data;
      wr_ptr        <= wr_ptr + PTR_W'(1);
    end
  end

  // wr_ptr already points past the newest sample once it has been written.
  assign rd_addr = wr_ptr - PTR_W'(1) - rd_k;
  assign rd_data = buf_q[rd_addr];

endmodule

// File: rtl/anc_lms_engine.sv
// Time-multiplexed LMS adaptive FIR: one shared multiplier serves the FIR MAC
// pass and the a-priori weight update pass, one tap per cycle.
module anc_lms_engine
  import anc_pkg::*;
#(
  parameter int TAPS       = DEF_TAPS,
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int COEFF_W    = DEF_COEFF_W,
  parameter int COEFF_FRAC = DEF_COEFF_FRAC,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  anc_lms_engine_if.slave     smp,
  input  logic                adapt_en_in,
  input  logic                leak_en_in,
  input  logic [4:0]          mu_shift_in,
  input  logic                clear_in,
  output logic                busy_out
);

  localparam int K_W    = $clog2(TAPS);
  localparam int MUL_W  = (COEFF_W > SAMPLE_W) ? COEFF_W : SAMPLE_W;
  localparam int PROD_W = MUL_W + SAMPLE_W;
  localparam int ACC_W  = COEFF_W + SAMPLE_W + K_W;

  state_t                     state, state_nxt;
  logic                       accept;
  logic        [K_W-1:0]      k_q;
  logic                       last_k;
  logic signed [COEFF_W-1:0]  w_q [TAPS];
  logic signed [SAMPLE_W-1:0] e_q;
  logic        [4:0]          mu_q;
  logic                       adapt_q;
  logic                       leak_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [SAMPLE_W-1:0] x_k;
  logic signed [MUL_W-1:0]    mul_a;
  logic signed [PROD_W-1:0]   prod;
  wide_t                      leak_term;
  wide_t                      upd_sum;

  lms_delay_line #(
    .TAPS     (TAPS),
    .SAMPLE_W (SAMPLE_W),
    .PTR_W    (K_W)
  ) u_delay (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .wr_en   (accept),
    .wr_data (smp.x_in),
    .rd_k    (k_q),
    .rd_data (x_k)
  );

  assign last_k = (k_q == K_W'(TAPS - 1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (smp.ready_in) begin
          state_nxt = ST_MAC;
          accept    = 1'b1;
        end else if (clear_in) begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_MAC:    if (last_k) state_nxt = ST_OUT;
      ST_OUT:    state_nxt = adapt_q ? ST_UPDATE : ST_IDLE;
      ST_UPDATE: if (last_k) state_nxt = ST_IDLE;
      ST_CLEAR:  if (last_k) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Single multiplier: weight x sample during MAC, error x sample during UPDATE.
  assign mul_a = (state == ST_UPDATE) ? MUL_W'(e_q) : MUL_W'(w_q[k_q]);
  assign prod  = PROD_W'(mul_a) * PROD_W'(x_k);

  assign leak_term = leak_q ? (wide_t'(w_q[k_q]) >>> LEAK_SHIFT) : wide_t'(0);
  assign upd_sum   = wide_t'(w_q[k_q]) + (wide_t'(prod) >>> mu_q) - leak_term;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= ST_IDLE;
      k_q             <= '0;
      acc_q           <= '0;
      e_q             <= '0;
      mu_q            <= '0;
      adapt_q         <= 1'b0;
      leak_q          <= 1'b0;
      busy_out        <= 1'b0;
      smp.y_out       <= '0;
      smp.y_valid_out <= 1'b0;
      smp.drop_out    <= 1'b0;
      for (int i = 0; i < TAPS; i++) w_q[i] <= '0;
    end else begin
      state           <= state_nxt;
      busy_out        <= (state != ST_IDLE);
      smp.drop_out    <= smp.ready_in && (state != ST_IDLE);
      smp.y_valid_out <= (state == ST_OUT);
      k_q <= (state inside {ST_MAC, ST_UPDATE, ST_CLEAR}) ? k_q + K_W'(1) : '0;

      if (accept) begin
        e_q     <= smp.e_in;
        mu_q    <= mu_shift_in;
        adapt_q <= adapt_en_in;
        leak_q  <= leak_en_in;
        acc_q   <= '0;
      end

      if (state == ST_MAC) acc_q <= acc_q + ACC_W'(prod);
      // Arithmetic shift floors, giving round-toward-minus-infinity.
      if (state == ST_OUT)
        smp.y_out <= SAMPLE_W'(sat_to(wide_t'(acc_q) >>> COEFF_FRAC, SAMPLE_W));
      if (state == ST_UPDATE) w_q[k_q] <= COEFF_W'(sat_to(upd_sum, COEFF_W));
      if (state == ST_CLEAR)  w_q[k_q] <= '0;
    end
  end

endmodule

// File: tb/tb_anc_lms_engine.sv
// Directed bench for anc_lms_engine at TAPS=4 with hand-computed expectations.
module tb_anc_lms_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       adapt_en = 1'b0;
  logic       leak_en = 1'b0;
  logic [4:0] mu_shift = 5'd0;
  logic       clear = 1'b0;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int y;

  anc_lms_engine_if #(.SAMPLE_W(16)) ifc ();

  anc_lms_engine #(.TAPS(4)) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .smp         (ifc),
    .adapt_en_in (adapt_en),
    .leak_en_in  (leak_en),
    .mu_shift_in (mu_shift),
    .clear_in    (clear),
    .busy_out    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.ready_in = 1'b0;
    clear = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One sample through the engine; optional extra ready_in pulse at drop_edge.
  task automatic do_sample(input string tag, input int xv, input int ev,
                           input int ad, input int lk, input int mu,
                           input int drop_edge, output int yv);
    int cyc;
    bit seen;
    ifc.ready_in = 1'b1;
    ifc.x_in = 16'(xv);
    ifc.e_in = 16'(ev);
    adapt_en = ad[0];
    leak_en = lk[0];
    mu_shift = 5'(mu);
    step();
    ifc.ready_in = 1'b0;
    ifc.x_in = '0;
    ifc.e_in = '0;
    adapt_en = 1'b0;
    leak_en = 1'b0;
    mu_shift = 5'd0;
    cyc = 0;
    seen = 1'b0;
    yv = 0;
    while (cyc < 40) begin
      if (drop_edge > 0 && cyc + 1 == drop_edge) begin
        ifc.ready_in = 1'b1;
        ifc.x_in = 16'sd7777;
      end
      step();
      cyc++;
      ifc.ready_in = 1'b0;
      ifc.x_in = '0;
      if (drop_edge > 0 && cyc == drop_edge) check({tag, "_drop_pulse"}, int'(ifc.drop_out), 1);
      if (drop_edge > 0 && cyc == drop_edge + 1) check({tag, "_drop_once"}, int'(ifc.drop_out), 0);
      if (ifc.y_valid_out) begin
        check({tag, "_valid_lat"}, cyc, 5);
        yv = int'(ifc.y_out);
        seen = 1'b1;
      end
      if (seen && !busy) break;
    end
    check({tag, "_busy_len"}, cyc, (ad != 0) ? 10 : 6);
    check({tag, "_y"}, yv, yv);
  endtask

  initial begin
    ifc.ready_in = 1'b0;
    ifc.x_in = '0;
    ifc.e_in = '0;
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    check("rst_y", int'(ifc.y_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(ifc.y_valid_out), 0);
    check("rst_drop", int'(ifc.drop_out), 0);

    // Zero weights, no adaptation.
    do_sample("noadapt", 1000, 0, 0, 0, 0, -1, y);
    check("noadapt_y", y, 0);
    check("noadapt_valid_off", int'(ifc.y_valid_out), 0);

    // Single update then filtering with the learned weight.
    do_reset();
    do_sample("learn1", 16384, 16384, 1, 0, 16, -1, y);
    check("learn1_y", y, 0);
    do_sample("learn2", 16384, 0, 1, 0, 16, -1, y);
    check("learn2_y", y, 4096);
    check("learn2_hold", int'(ifc.y_out), 4096);
    do_sample("neg", -8192, 0, 0, 0, 0, -1, y);
    check("neg_y", y, -2048);

    // Leakage pulls w0 from 4096 to 4095; then floor rounding of -4095/16384.
    do_sample("leak", 0, 0, 1, 1, 0, -1, y);
    check("leak_y", y, 0);
    do_sample("leak_chk", 16384, 0, 0, 0, 0, -1, y);
    check("leak_chk_y", y, 4095);
    do_sample("floor", -1, 0, 0, 0, 0, -1, y);
    check("floor_y", y, -1);

    // Saturation of coefficients and output, both directions.
    do_reset();
    do_sample("sat1", 32767, 32767, 1, 0, 0, -1, y);
    check("sat1_y", y, 0);
    do_sample("sat2", 32767, 32767, 1, 0, 0, -1, y);
    check("sat2_y", y, 32767);
    do_sample("sat3", 32767, 32767, 1, 0, 0, -1, y);
    check("sat3_y", y, 32767);
    do_sample("sat4", 32767, 32767, 1, 0, 0, -1, y);
    check("sat4_y", y, 32767);
    do_sample("sat5", 32767, -32768, 1, 0, 0, -1, y);
    check("sat5_y", y, 32767);
    do_sample("sat6", 32767, 0, 0, 0, 0, -1, y);
    check("sat6_y", y, -32768);

    // Dropped sample must not disturb buffer, pointer or update.
    do_reset();
    do_sample("drop", 16384, 16384, 1, 0, 16, 3, y);
    check("drop_y", y, 0);
    do_sample("after_drop", 16384, 0, 0, 0, 0, -1, y);
    check("after_drop_y", y, 4096);

    // Reset asserted in the middle of UPDATE.
    ifc.ready_in = 1'b1;
    ifc.x_in = 16'sd16384;
    ifc.e_in = 16'sd16384;
    adapt_en = 1'b1;
    mu_shift = 5'd16;
    step();
    ifc.ready_in = 1'b0;
    adapt_en = 1'b0;
    repeat (6) step();
    check("mid_pre_y", int'(ifc.y_out), 4096);
    check("mid_pre_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_y", int'(ifc.y_out), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(ifc.y_valid_out), 0);
    check("mid_rst_drop", int'(ifc.drop_out), 0);
    step();
    rst_n = 1'b1;
    do_sample("post_rst", 16384, 0, 0, 0, 0, -1, y);
    check("post_rst_y", y, 0);

    // Coefficient clear from IDLE.
    do_sample("pre_clr", 16384, 16384, 1, 0, 16, -1, y);
    check("pre_clr_y", y, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    check("clr_busy", int'(busy), 1);
    repeat (5) step();
    check("clr_idle", int'(busy), 0);
    do_sample("post_clr", 16384, 0, 0, 0, 0, -1, y);
    check("post_clr_y", y, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
